pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch stage: the consumer of the branch unit's `PCSrc` decision. Holds the PC and issues one instruction-memory read at a time over a req/gnt/rvalid interface. Presents each fetched instruction with its PC to decode over a valid/ready handshake. On a taken-branch redirect it retargets the PC and squashes any wrong-path fetch, whether in flight or buffered.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `i_clk`  in  1: single clock; all state updates on the rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_PCSrc`  in  1: redirect request from the branch unit; sampled on every clock edge.
- `i_branch_target`  in  32: redirect target; bits [1:0] are ignored (forced to 00).
- `o_imem_req`  out  1: read request to instruction memory.
- `o_imem_addr`  out  32: read address (the current PC).
- `i_imem_gnt`  in  1: request accepted this cycle.
- `i_imem_rvalid`  in  1: read data valid.
- `i_imem_rdata`  in  32: instruction word.
- `o_valid`  out  1: instruction available to decode.
- `i_ready`  in  1: decode accepts the instruction.
- `o_instr`  out  32: fetched instruction.
- `o_pc`  out  32: PC of `o_instr`.

## Operation
- States:
  - S_BOOT (reset state)
  - S_REQ
  - S_WAIT
  - S_HOLD
- Internal registers: `pc`, `kill` flag, output buffer (`o_instr`, `o_pc`, `o_valid`).
- S_BOOT: `o_imem_req`=0; moves to S_REQ on the next edge.
- S_REQ: `o_imem_req`=1, `o_imem_addr`=`pc`.
  - On `i_imem_gnt`: go to S_WAIT.
  - Otherwise stay in S_REQ.
  - Memory does not require the address to stay stable while the request is unaccepted.
- S_WAIT: `o_imem_req`=0. On `i_imem_rvalid`:
  - If `kill`=1: drop the data, clear `kill`, go to S_REQ.
  - Otherwise: `o_instr`<=rdata, `o_pc`<=`pc`, `o_valid`<=1, go to S_HOLD.
- S_HOLD: `o_valid`=1, buffer held stable, no memory request.
  - On `i_ready`: `o_valid`<=0, `pc`<=`pc`+4, go to S_REQ.
- `i_imem_rvalid` is ignored in every state except S_WAIT.
- Redirect (`i_PCSrc`=1 at an edge) takes priority over every other event:
  - `pc` <= {`i_branch_target`[31:2], 2'b00} in all states; the most recent redirect wins.
  - S_REQ without gnt: stay in S_REQ; the new address appears next cycle.
  - S_REQ with gnt in the same cycle: go to S_WAIT with `kill`<=1.
  - S_WAIT: `kill`<=1; stay in S_WAIT until rvalid.
  - S_HOLD: `o_valid`<=0 and the buffered instruction is squashed, even if `i_ready`=1 in the same cycle. Go to S_REQ.
  - S_BOOT: `pc` is updated; go to S_REQ as normal.
- Arithmetic: `pc`+4 is modulo 2^32, so 0xFFFF_FFFC increments to 0x0000_0000.
- At most one request is outstanding; responses are in order.

## Timing
- Reset values (asynchronous, held while `i_rst_n`=0):
  - state=S_BOOT, `pc`=`RESET_PC`, `kill`=0
  - `o_imem_req`=0, `o_imem_addr`=`RESET_PC`
  - `o_valid`=0, `o_instr`=0, `o_pc`=`RESET_PC`
- First `o_imem_req`=1: one cycle after the first edge with `i_rst_n`=1.
- Latency: gnt in cycle N, rvalid in cycle M>N, then `o_valid`=1 in cycle M+1.
- Steady state with zero wait states: one instruction every 3 cycles (REQ, WAIT, HOLD).
- Redirect latency: target on `o_imem_addr` in the next cycle from S_REQ/S_HOLD. From S_WAIT, it appears the cycle after the killed rvalid.
- Reset asserted mid-operation clears everything immediately. A response arriving after reset release, outside S_WAIT, is ignored.

## Test plan
- Boot: `RESET_PC`=0, gnt at first request, rvalid next cycle with 0x0050_0093. Required: `o_valid`=1 with `o_pc`=0 and `o_instr`=0x0050_0093; after `i_ready`, next request at 0x4.
- Backpressure: hold `i_ready`=0 for 5 cycles in S_HOLD. Required: `o_valid`, `o_instr`, `o_pc` stable, `o_imem_req`=0 throughout; the accept then yields a request at `pc`+4.
- Kill in flight: `i_PCSrc`=1 with target 0x100 while in S_WAIT, then rvalid with 0xDEAD_BEEF. Required: `o_valid` never rises for 0xDEAD_BEEF; next request address is 0x100.
- Squash beats handshake: in S_HOLD drive `i_PCSrc`=1 (target 0x200) and `i_ready`=1 together. Required: `o_valid`=0 next cycle, request address 0x200, and the buffered PC is not incremented.
- Alignment and wrap: target 0x103 gives request address 0x100. Fetching at 0xFFFF_FFFC followed by an accept gives a request at 0x0.
- Reset mid-WAIT: drop `i_rst_n` asynchronously in S_WAIT. Required: outputs take reset values without waiting for a clock edge; a stale rvalid 1 cycle after release causes no `o_valid`.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: one outstanding imem read at a time,
// a one-entry output buffer toward decode, and redirect/squash of wrong-path fetches.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_PCSrc,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] target;
  logic        accept;
  logic        drain;

  assign target = {i_branch_target[31:2], 2'b00};

  // A good response is buffered only if nothing marked it wrong-path, including a redirect this cycle.
  assign accept = (state == S_WAIT) && i_imem_rvalid && !kill && !i_PCSrc;
  assign drain  = (state == S_HOLD) && (i_PCSrc || i_ready);

  assign o_imem_req  = (state == S_REQ);
  assign o_imem_addr = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ:  if (i_imem_gnt) state_nxt = S_WAIT;
      S_WAIT: begin
        // A redirect coinciding with the response drops it; no further response would come.
        if (i_imem_rvalid) state_nxt = accept ? S_HOLD : S_REQ;
      end
      S_HOLD: if (drain) state_nxt = S_REQ;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc      <= RESET_PC;
      kill    <= 1'b0;
      o_valid <= 1'b0;
      o_instr <= 32'h0;
      o_pc    <= RESET_PC;
    end else begin
      if (i_PCSrc)
        pc <= target;
      else if ((state == S_HOLD) && i_ready)
        pc <= pc + 32'd4;

      if ((state == S_REQ) && i_imem_gnt && i_PCSrc)
        kill <= 1'b1;
      else if ((state == S_WAIT) && i_imem_rvalid)
        kill <= 1'b0;
      else if ((state == S_WAIT) && i_PCSrc)
        kill <= 1'b1;

      if (accept) begin
        o_valid <= 1'b1;
        o_instr <= i_imem_rdata;
        o_pc    <= pc;
      end else if (drain) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by random traffic, all outputs
// compared every cycle against a transaction-level fetch model.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        pcsrc;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] opc;

  int n_cmp;
  int n_err;

  // Reference model: fetch progress described as booleans about the outstanding read and buffer.
  logic        m_booted;
  logic        m_outstanding;
  logic        m_wrong;
  logic        m_full;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_bpc;

  pc_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_PCSrc        (pcsrc),
    .i_branch_target(target),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_gnt     (gnt),
    .i_imem_rvalid  (rvalid),
    .i_imem_rdata   (rdata),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_instr        (instr),
    .o_pc           (opc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted      = 1'b0;
    m_outstanding = 1'b0;
    m_wrong       = 1'b0;
    m_full        = 1'b0;
    m_pc          = RST_PC;
    m_instr       = 32'h0;
    m_bpc         = RST_PC;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    tgt = target & 32'hFFFF_FFFC;
    if (!rst_n) begin
      model_reset();
    end else if (!m_booted) begin
      m_booted = 1'b1;
      if (pcsrc) m_pc = tgt;
    end else if (m_full) begin
      if (pcsrc) begin
        m_full = 1'b0;
        m_pc   = tgt;
      end else if (ready) begin
        m_full = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
    end else if (m_outstanding) begin
      if (rvalid) begin
        m_outstanding = 1'b0;
        if (!m_wrong && !pcsrc) begin
          m_full  = 1'b1;
          m_instr = rdata;
          m_bpc   = m_pc;
        end
        m_wrong = 1'b0;
      end else if (pcsrc) begin
        m_wrong = 1'b1;
      end
      if (pcsrc) m_pc = tgt;
    end else begin
      if (gnt) begin
        m_outstanding = 1'b1;
        m_wrong       = pcsrc;
      end
      if (pcsrc) m_pc = tgt;
    end
  endtask

  task automatic compare_all();
    check("req",   {31'b0, imem_req}, {31'b0, m_booted && !m_outstanding && !m_full});
    check("addr",  imem_addr, m_pc);
    check("valid", {31'b0, valid}, {31'b0, m_full});
    check("instr", instr, m_instr);
    check("opc",   opc, m_bpc);
  endtask

  // Inputs are set at the falling edge before this call; outputs are checked at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    pcsrc  = 1'b0;
    target = 32'h0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'h0;
    ready  = 1'b0;
    model_reset();

    #3;
    check("rst_req",   {31'b0, imem_req}, 32'h0);
    check("rst_addr",  imem_addr, RST_PC);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_opc",   opc, RST_PC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("boot_req", {31'b0, imem_req}, 32'h1);

    // Boot fetch
    gnt = 1'b1; cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093; cyc();
    rvalid = 1'b0;
    check("boot_valid", {31'b0, valid}, 32'h1);
    check("boot_instr", instr, 32'h0050_0093);
    check("boot_opc",   opc, 32'h0);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      rvalid = 1'b1; rdata = 32'h1234_5678;
      cyc();
      check("bp_instr", instr, 32'h0050_0093);
      check("bp_req",   {31'b0, imem_req}, 32'h0);
    end
    rvalid = 1'b0; ready = 1'b1; cyc();
    ready = 1'b0;
    check("bp_next_addr", imem_addr, 32'h4);

    // Kill in flight
    gnt = 1'b1; cyc();
    gnt = 1'b0; pcsrc = 1'b1; target = 32'h100; cyc();
    pcsrc = 1'b0; cyc();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; cyc();
    rvalid = 1'b0;
    check("kill_valid", {31'b0, valid}, 32'h0);
    check("kill_addr",  imem_addr, 32'h100);
    cyc();
    check("kill_valid2", {31'b0, valid}, 32'h0);

    // Squash beats handshake
    gnt = 1'b1; cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013; cyc();
    rvalid = 1'b0;
    check("sq_opc", opc, 32'h100);
    pcsrc = 1'b1; target = 32'h200; ready = 1'b1; cyc();
    pcsrc = 1'b0; ready = 1'b0;
    check("sq_valid", {31'b0, valid}, 32'h0);
    check("sq_addr",  imem_addr, 32'h200);

    // Alignment and wrap
    pcsrc = 1'b1; target = 32'h103; cyc();
    check("align_addr", imem_addr, 32'h100);
    target = 32'hFFFF_FFFC; cyc();
    pcsrc = 1'b0;
    gnt = 1'b1; cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0001; cyc();
    rvalid = 1'b0;
    check("wrap_opc", opc, 32'hFFFF_FFFC);
    ready = 1'b1; cyc();
    ready = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset while waiting on a response
    gnt = 1'b1; cyc();
    gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("ar_req",  {31'b0, imem_req}, 32'h0);
    check("ar_addr", imem_addr, RST_PC);
    check("ar_opc",  opc, RST_PC);
    check("ar_instr", instr, 32'h0);
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    cyc();
    cyc();
    rvalid = 1'b0;
    check("ar_stale_valid", {31'b0, valid}, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      gnt    = ($urandom_range(0, 1) == 1);
      rvalid = ($urandom_range(0, 9) < 4);
      rdata  = $urandom;
      ready  = ($urandom_range(0, 9) < 6);
      pcsrc  = ($urandom_range(0, 9) == 0);
      target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
